// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave: FSM state encoding, synchronizer depth,
// and the mapping from CPOL/CPHA to the SCLK edge on which data is sampled.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

    localparam int SYNC_STAGES = 2;

    // 1 when mosi is sampled on the rising SCLK edge, 0 when on the falling edge.
    // The shift edge is always the opposite one.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by rise/fall pulse detection
// on the synchronized level. RESET_VAL presets the chain to the pin's inactive level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running on the system clock with oversampled SCLK/CS_N/MOSI.
// Bit order is MSB-first unless SPI_SLAVE_LSB_FIRST_EN is defined (LSB-first both ways).
// Handshake: tx_load is accepted only while tx_ready=1; rx_valid is a 1-cycle pulse
// qualifying rx_data, which then holds until the next completed word.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int   DATA_W = 8,
    parameter logic CPOL   = 1'b0,
    parameter logic CPHA   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int   CNT_W       = $clog2(DATA_W);
    localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    spi_state_e             state, state_next;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;
    logic                   sample_edge, shift_edge;
    logic                   start, do_sample, do_shift, consume;
    logic [DATA_W-1:0]      tx_buf, tx_shift, rx_shift;
    logic [DATA_W-1:0]      load_word, shift_adv, rx_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   reload_pending, hold_first, out_bit;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
        .clk (clk), .rst (rst), .din (sclk), .rise (sclk_rise), .fall (sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk (clk), .rst (rst), .din (cs_n), .rise (cs_rise), .fall (cs_fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mosi_q <= '0;
        else      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign out_bit   = tx_shift[0];
    assign shift_adv = {1'b0, tx_shift[DATA_W-1:1]};
    assign rx_next   = {mosi_s, rx_shift[DATA_W-1:1]};
`else
    assign out_bit   = tx_shift[DATA_W-1];
    assign shift_adv = {tx_shift[DATA_W-2:0], 1'b0};
    assign rx_next   = {rx_shift[DATA_W-2:0], mosi_s};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A shift edge coinciding with deselect is dropped so it cannot consume the buffer.
    always_comb begin
        busy      = (state == SHIFT);
        miso_oe   = busy;
        start     = (state == IDLE) && cs_fall;
        do_sample = busy && sample_edge;
        do_shift  = busy && shift_edge && !cs_rise;
    end

    assign miso      = busy & out_bit;
    assign load_word = tx_ready ? '0 : tx_buf;
    assign consume   = !tx_ready && (start || (do_shift && !hold_first && reload_pending));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf   <= '0;
            tx_ready <= 1'b1;
        end else if (consume) begin
            tx_ready <= 1'b1;
        end else if (tx_load && tx_ready) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift       <= '0;
            rx_shift       <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
            hold_first     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start) begin
                tx_shift       <= load_word;
                bit_cnt        <= '0;
                reload_pending <= 1'b0;
                hold_first     <= CPHA;
            end
            if (do_sample) begin
                rx_shift <= rx_next;
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    rx_data        <= rx_next;
                    rx_valid       <= 1'b1;
                    bit_cnt        <= '0;
                    reload_pending <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            // With CPHA=1 the first shift edge only confirms the bit already on miso.
            if (do_shift) begin
                if (hold_first) begin
                    hold_first <= 1'b0;
                end else if (reload_pending) begin
                    tx_shift       <= load_word;
                    reload_pending <= 1'b0;
                end else begin
                    tx_shift <= shift_adv;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: instance 0 runs mode 0 (CPOL=0,CPHA=0), instance 1 runs mode 3
// (CPOL=1,CPHA=1). A task-driven SPI master plays frames against a word-level model.
module tb_spi_slave_sync;

    localparam int HALF = 4;

    logic       clk;
    logic       rst;
    logic [1:0] sclk, cs_n, mosi, miso, miso_oe, tx_load, tx_ready, rx_valid, busy;
    logic [7:0] tx_data [2];
    logic [7:0] rx_data [2];

    logic [7:0] txq   [2][$];
    logic [7:0] exp_q [2][$];
    logic [7:0] last_exp [2];

    int checks = 0;
    int errors = 0;

    spi_slave_sync #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .clk (clk), .rst (rst), .sclk (sclk[0]), .cs_n (cs_n[0]), .mosi (mosi[0]),
        .miso (miso[0]), .miso_oe (miso_oe[0]), .tx_data (tx_data[0]), .tx_load (tx_load[0]),
        .tx_ready (tx_ready[0]), .rx_data (rx_data[0]), .rx_valid (rx_valid[0]), .busy (busy[0])
    );

    spi_slave_sync #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
        .clk (clk), .rst (rst), .sclk (sclk[1]), .cs_n (cs_n[1]), .mosi (mosi[1]),
        .miso (miso[1]), .miso_oe (miso_oe[1]), .tx_data (tx_data[1]), .tx_load (tx_load[1]),
        .tx_ready (tx_ready[1]), .rx_data (rx_data[1]), .rx_valid (rx_valid[1]), .busy (busy[1])
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Position within the word of the i-th bit on the wire.
    function automatic int bit_idx(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return i;
`else
        return 7 - i;
`endif
    endfunction

    // Model buffer accepts a load only while empty.
    task automatic load_tx(input int d, input logic [7:0] w);
        tx_data[d] = w;
        tx_load[d] = 1'b1;
        wait_clks(1);
        tx_load[d] = 1'b0;
        if (txq[d].size() == 0) txq[d].push_back(w);
    endtask

    task automatic check_idle_reset(input int d);
        check("rst_miso", miso[d], 1'b0);
        check("rst_miso_oe", miso_oe[d], 1'b0);
        check("rst_tx_ready", tx_ready[d], 1'b1);
        check("rst_rx_data", rx_data[d], 8'h00);
        check("rst_rx_valid", rx_valid[d], 1'b0);
        check("rst_busy", busy[d], 1'b0);
    endtask

    // Master side of one frame of nw words. abort_at>0 deselects after that many bits.
    // early_cs raises cs_n together with the final sample edge.
    task automatic frame(input int d, input int nw, input logic [7:0] m0, input logic [7:0] m1,
                         input int abort_at, input bit load2, input logic [7:0] t2,
                         input bit early_cs);
        logic [7:0] mw, et;
        int         nb, idx;
        logic       cpol, cpha;
        bit         last;
        cpol = (d == 1);
        cpha = (d == 1);
        cs_n[d] = 1'b0;
        wait_clks(HALF);
        for (int w = 0; w < nw; w++) begin
            mw = (w == 0) ? m0 : m1;
            et = 8'h00;
            if (txq[d].size() > 0) et = txq[d].pop_front();
            nb = (abort_at > 0) ? abort_at : 8;
            if (abort_at == 0) begin
                exp_q[d].push_back(mw);
                last_exp[d] = mw;
            end
            for (int i = 0; i < nb; i++) begin
                idx  = bit_idx(i);
                last = (w == nw - 1) && (i == nb - 1);
                if (!cpha) begin
                    mosi[d] = mw[idx];
                    wait_clks(HALF);
                end else begin
                    sclk[d] = ~cpol;
                    mosi[d] = mw[idx];
                    wait_clks(HALF);
                end
                check("miso", miso[d], et[idx]);
                check("tx_ready", tx_ready[d], txq[d].size() == 0);
                if (i == 0) check("busy", busy[d] & miso_oe[d], 1'b1);
                if (early_cs && last) cs_n[d] = 1'b1;
                if (!cpha) begin
                    sclk[d] = ~cpol;
                    wait_clks(HALF);
                    sclk[d] = cpol;
                end else begin
                    sclk[d] = cpol;
                    wait_clks(HALF);
                end
                if (load2 && w == 0 && i == 3) load_tx(d, t2);
                if (load2 && w == 0 && i == 5) load_tx(d, ~t2);
            end
        end
        wait_clks(HALF);
        cs_n[d] = 1'b1;
        wait_clks(3);
        check("miso_oe_off", miso_oe[d], 1'b0);
        check("busy_off", busy[d], 1'b0);
        wait_clks(4);
        check("rx_count", exp_q[d].size(), 0);
        check("rx_hold", rx_data[d], last_exp[d]);
    endtask

    // Scoreboard: every rx_valid pulse must match the next word the master completed.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst && rx_valid[d]) begin
                if (exp_q[d].size() == 0) check("rx_unexpected", rx_data[d], 32'hdead);
                else check("rx_data", rx_data[d], exp_q[d].pop_front());
            end
        end
    end

    initial begin
        int         d, nw, ab;
        bit         l2, ec;
        rst      = 1'b0;
        sclk     = 2'b10;
        cs_n     = 2'b11;
        mosi     = 2'b00;
        tx_load  = 2'b00;
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;
        last_exp[0] = 8'h00;
        last_exp[1] = 8'h00;
        wait_clks(3);
        check_idle_reset(0);
        check_idle_reset(1);
        rst = 1'b1;
        wait_clks(3);

        // Directed frames
        load_tx(0, 8'hCC);
        frame(0, 1, 8'hAA, 8'h00, 0, 1'b0, 8'h00, 1'b0);
        load_tx(0, 8'h3C);
        frame(0, 2, 8'h01, 8'h02, 0, 1'b1, 8'h5A, 1'b0);
        frame(0, 1, 8'hFF, 8'h00, 0, 1'b0, 8'h00, 1'b0);
        frame(0, 1, 8'h55, 8'h00, 5, 1'b0, 8'h00, 1'b0);
        frame(0, 1, 8'h81, 8'h00, 0, 1'b0, 8'h00, 1'b0);
        load_tx(1, 8'hA5);
        frame(1, 1, 8'h96, 8'h00, 0, 1'b0, 8'h00, 1'b0);
        load_tx(1, 8'h3E);
        frame(1, 2, 8'hC3, 8'h7E, 0, 1'b1, 8'h19, 1'b1);
        frame(0, 1, 8'h6D, 8'h00, 0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of a word
        load_tx(0, 8'h33);
        cs_n[0] = 1'b0;
        wait_clks(HALF);
        mosi[0] = 1'b1;
        sclk[0] = 1'b1;
        wait_clks(HALF);
        sclk[0] = 1'b0;
        wait_clks(HALF);
        sclk[0] = 1'b1;
        wait_clks(2);
        #3 rst = 1'b0;
        #1;
        check_idle_reset(0);
        cs_n    = 2'b11;
        sclk[0] = 1'b0;
        mosi    = 2'b00;
        for (int k = 0; k < 2; k++) begin
            txq[k].delete();
            exp_q[k].delete();
            last_exp[k] = 8'h00;
        end
        wait_clks(2);
        rst = 1'b1;
        wait_clks(4);
        load_tx(0, 8'h0F);
        frame(0, 1, 8'hF0, 8'h00, 0, 1'b0, 8'h00, 1'b0);

        // Randomized frames
        for (int k = 0; k < 40; k++) begin
            d = $urandom_range(0, 1);
            if ($urandom_range(0, 2) != 0) load_tx(d, 8'($urandom));
            nw = $urandom_range(1, 2);
            ab = 0;
            if (nw == 1 && $urandom_range(0, 4) == 0) ab = $urandom_range(1, 7);
            l2 = (nw == 2) && ($urandom_range(0, 1) == 1);
            ec = (ab == 0) && ($urandom_range(0, 3) == 0);
            frame(d, nw, 8'($urandom), 8'($urandom), ab, l2, 8'($urandom), ec);
        end

        wait_clks(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
